// File: rtl/dma_prog_seq_pkg.sv
// Shared definitions for the DMA channel programming sequencer: channel instruction codes,
// control-field layout and FSM state encoding.
package dma_prog_seq_pkg;

  localparam logic [2:0] INS_LDCTRL = 3'b000;
  localparam logic [2:0] INS_RDCTRL = 3'b001;
  localparam logic [2:0] INS_RDWORD = 3'b010;
  localparam logic [2:0] INS_RDADDR = 3'b011;
  localparam logic [2:0] INS_REINIT = 3'b100;
  localparam logic [2:0] INS_LDADDR = 3'b101;
  localparam logic [2:0] INS_LDWORD = 3'b110;
  localparam logic [2:0] INS_STEP   = 3'b111;
  // RDADDR has no side effects on the channel, so it doubles as the idle code.
  localparam logic [2:0] INS_NOP    = INS_RDADDR;

  localparam int unsigned CTRL_DEC_BIT  = 2;
  localparam int unsigned CTRL_MODE_MSB = 1;
  localparam int unsigned CTRL_MODE_LSB = 0;

  localparam logic [1:0] MODE_WORDS_DOWN = 2'b00;
  localparam logic [1:0] MODE_WORDS_UP   = 2'b01;
  localparam logic [1:0] MODE_ADDR_CMP   = 2'b10;
  localparam logic [1:0] MODE_FREE_RUN   = 2'b11;

  // Upper bits the channel returns alongside the control field on RDCTRL.
  localparam logic [4:0] RDCTRL_TAG = 5'b11111;

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StLdCtrl = 4'd1;
  localparam logic [3:0] StRdCtrl = 4'd2;
  localparam logic [3:0] StLdAddr = 4'd3;
  localparam logic [3:0] StLdWord = 4'd4;
  localparam logic [3:0] StReinit = 4'd5;
  localparam logic [3:0] StStep   = 4'd6;
  localparam logic [3:0] StRdAddr = 4'd7;
  localparam logic [3:0] StRdWord = 4'd8;
  localparam logic [3:0] StFin    = 4'd9;

endpackage

// File: rtl/dma_prog_seq.sv
// Host-side programming sequencer for one DMA channel: loads and verifies the channel setup,
// issues one STEP per ready request until the channel reports done, then reads back final state.
module dma_prog_seq
  import dma_prog_seq_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] cfg_ctrl,
  input  logic [7:0] cfg_addr,
  input  logic [7:0] cfg_words,
  input  logic       req,
  input  logic       ch_done,
  input  logic [7:0] ch_dout,
  output logic [2:0] ch_instr,
  output logic [7:0] ch_din,
  output logic       busy,
  output logic       finished,
  output logic       err,
  output logic [7:0] final_addr,
  output logic [7:0] final_words,
  output logic [8:0] step_cnt
);

  localparam logic [8:0] StepLast = 9'(MAX_STEPS - 1);

  logic [3:0] state_q, state_d;
  logic [2:0] ctrl_q;
  logic [7:0] addr_q, words_q;
  logic [2:0] instr_d;
  logic [7:0] din_d;
  logic       err_d;
  logic [7:0] final_addr_d, final_words_d;
  logic [8:0] step_cnt_d;
  logic       step_issued;
  logic       abortable;

  // ch_instr is registered, so a STEP is only on the bus when the previous cycle chose it.
  assign step_issued = (state_q == StStep) && (ch_instr == INS_STEP);
  assign abortable   = (state_q != StIdle) && (state_q != StFin);
  assign busy        = (state_q != StIdle);
  assign finished    = (state_q == StFin);

  always_comb begin
    state_d       = state_q;
    err_d         = err;
    step_cnt_d    = step_cnt;
    final_addr_d  = final_addr;
    final_words_d = final_words;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLdCtrl;
          err_d      = 1'b0;
          step_cnt_d = '0;
        end
      end
      StLdCtrl: state_d = StRdCtrl;
      StRdCtrl: begin
        if (ch_dout != {RDCTRL_TAG, ctrl_q}) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          state_d = StLdAddr;
        end
      end
      StLdAddr: state_d = StLdWord;
      StLdWord: state_d = StReinit;
      StReinit: state_d = StStep;
      StStep: begin
        if (step_issued) begin
          step_cnt_d = step_cnt + 9'd1;
          if (ch_done) begin
            state_d = StRdAddr;
          end else if (step_cnt == StepLast) begin
            err_d   = 1'b1;
            state_d = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        final_addr_d = ch_dout;
        state_d      = StRdWord;
      end
      StRdWord: begin
        final_words_d = ch_dout;
        state_d       = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Abort overrides any capture or step decision made this cycle; the step count stands.
    if (abort && abortable) begin
      state_d       = StFin;
      err_d         = 1'b1;
      final_addr_d  = final_addr;
      final_words_d = final_words;
    end
  end

  always_comb begin
    instr_d = INS_NOP;
    din_d   = '0;
    case (state_d)
      StLdCtrl: begin
        instr_d = INS_LDCTRL;
        // Only reached from IDLE on the start edge, before ctrl_q holds the new value.
        din_d   = {5'b0, cfg_ctrl};
      end
      StRdCtrl: instr_d = INS_RDCTRL;
      StLdAddr: begin
        instr_d = INS_LDADDR;
        din_d   = addr_q;
      end
      StLdWord: begin
        instr_d = INS_LDWORD;
        din_d   = words_q;
      end
      StReinit: instr_d = INS_REINIT;
      StStep:   instr_d = req ? INS_STEP : INS_NOP;
      StRdWord: instr_d = INS_RDWORD;
      default:  instr_d = INS_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ctrl_q      <= '0;
      addr_q      <= '0;
      words_q     <= '0;
      ch_instr    <= INS_NOP;
      ch_din      <= '0;
      err         <= 1'b0;
      final_addr  <= '0;
      final_words <= '0;
      step_cnt    <= '0;
    end else begin
      state_q     <= state_d;
      ch_instr    <= instr_d;
      ch_din      <= din_d;
      err         <= err_d;
      final_addr  <= final_addr_d;
      final_words <= final_words_d;
      step_cnt    <= step_cnt_d;
      if ((state_q == StIdle) && start) begin
        ctrl_q  <= cfg_ctrl;
        addr_q  <= cfg_addr;
        words_q <= cfg_words;
      end
    end
  end

endmodule

// File: tb/tb_dma_prog_seq.sv
// Bench for dma_prog_seq: behavioural DMA channel as responder, directed scenarios plus
// randomized runs checked against an arithmetic model of step count, final state and timing.
module tb_dma_prog_seq;
  import dma_prog_seq_pkg::*;

  localparam int unsigned MaxSteps = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, abort = 1'b0, req = 1'b0;
  logic [2:0] cfg_ctrl = '0;
  logic [7:0] cfg_addr = '0, cfg_words = '0;
  logic       ch_done;
  logic [7:0] ch_dout;
  logic [2:0] ch_instr;
  logic [7:0] ch_din;
  logic       busy, finished, err;
  logic [7:0] final_addr, final_words;
  logic [8:0] step_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_prog_seq #(.MAX_STEPS(MaxSteps)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_ctrl(cfg_ctrl),
    .cfg_addr(cfg_addr), .cfg_words(cfg_words), .req(req), .ch_done(ch_done),
    .ch_dout(ch_dout), .ch_instr(ch_instr), .ch_din(ch_din), .busy(busy),
    .finished(finished), .err(err), .final_addr(final_addr), .final_words(final_words),
    .step_cnt(step_cnt)
  );

  // Behavioural DMA channel.
  logic [2:0] m_ctrl;
  logic [7:0] m_base, m_lim, m_addr, m_words, m_next_addr;
  logic       m_done;
  bit         corrupt = 0;

  always_comb begin
    m_next_addr = m_ctrl[CTRL_DEC_BIT] ? m_addr - 8'd1 : m_addr + 8'd1;
    case (m_ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB])
      MODE_WORDS_DOWN: m_done = (m_words == 8'd1);
      MODE_WORDS_UP:   m_done = ((m_words + 8'd1) == m_lim);
      MODE_ADDR_CMP:   m_done = (m_next_addr == m_lim);
      default:         m_done = 1'b0;
    endcase
    ch_done = (ch_instr == INS_STEP) && m_done;
    case (ch_instr)
      INS_RDCTRL: ch_dout = corrupt ? 8'h00 : {5'b11111, m_ctrl};
      INS_RDWORD: ch_dout = m_words;
      INS_RDADDR: ch_dout = m_addr;
      default:    ch_dout = 8'h00;
    endcase
  end

  always @(posedge clk) begin
    if (reset) begin
      m_ctrl <= '0; m_base <= '0; m_lim <= '0; m_addr <= '0; m_words <= '0;
    end else begin
      case (ch_instr)
        INS_LDCTRL: m_ctrl <= ch_din[2:0];
        INS_LDADDR: m_base <= ch_din;
        INS_LDWORD: m_lim <= ch_din;
        INS_REINIT: begin
          m_addr  <= m_base;
          m_words <= (m_ctrl[1:0] == MODE_WORDS_UP) ? 8'd0 : m_lim;
        end
        INS_STEP: begin
          m_addr <= m_next_addr;
          if (m_ctrl[1:0] == MODE_WORDS_DOWN) m_words <= m_words - 8'd1;
          else if (m_ctrl[1:0] == MODE_WORDS_UP) m_words <= m_words + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Per-run observations and expected values.
  bit         req_pat[512];
  int         obs_steps, obs_bad, obs_cycles;
  bit         obs_fin;
  int         e_steps, e_cycles;
  bit         e_err;
  logic [7:0] e_fa, e_fw;
  logic [7:0] last_fa = '0, last_fw = '0;

  function automatic void fill_req(input int pct);
    for (int i = 0; i < 512; i++) req_pat[i] = ($urandom_range(0, 99) < pct);
  endfunction

  // Steps the channel needs before done, capped by the step limit.
  function automatic void ref_run(input logic [2:0] c, input logic [7:0] a, input logic [7:0] w);
    int  need;
    logic dec;
    dec = c[CTRL_DEC_BIT];
    case (c[1:0])
      2'b00, 2'b01: need = (w == 8'd0) ? 256 : int'(w);
      2'b10: begin
        need = dec ? ((int'(a) - int'(w)) & 255) : ((int'(w) - int'(a)) & 255);
        if (need == 0) need = 256;
      end
      default: need = 100000;
    endcase
    e_err   = (need > int'(MaxSteps));
    e_steps = e_err ? int'(MaxSteps) : need;
    e_fa    = dec ? a - 8'(e_steps) : a + 8'(e_steps);
    case (c[1:0])
      2'b00:   e_fw = w - 8'(e_steps);
      2'b01:   e_fw = 8'(e_steps);
      default: e_fw = w;
    endcase
    // Cycle 0 is the start cycle; slot t (from 6) carries a STEP iff req was high in cycle t-1.
    e_cycles = -1;
    begin
      int issued = 0;
      for (int t = 6; t < 400; t++) begin
        if (req_pat[t-1]) issued++;
        if (issued == e_steps) begin
          e_cycles = t + 3;
          break;
        end
      end
    end
  endfunction

  task automatic do_run(input logic [2:0] c, input logic [7:0] a, input logic [7:0] w,
                        input int abort_step);
    bit aborted = 0;
    obs_steps = 0; obs_bad = 0; obs_fin = 0; obs_cycles = -1;
    @(posedge clk); #1;
    start = 1; cfg_ctrl = c; cfg_addr = a; cfg_words = w;
    for (int k = 0; k < 400; k++) begin
      req = req_pat[k];
      @(negedge clk);
      if (ch_instr == INS_STEP) obs_steps++;
      if (ch_instr inside {INS_LDADDR, INS_LDWORD, INS_REINIT, INS_STEP}) obs_bad++;
      if (abort_step > 0 && !aborted && ch_instr == INS_STEP && obs_steps == abort_step) begin
        abort = 1; aborted = 1;
      end
      if (finished) begin
        obs_fin = 1; obs_cycles = k;
        break;
      end
      @(posedge clk); #1;
      start = 0; abort = 0;
      // Inputs wander after the start edge; the run must use the latched copy.
      cfg_ctrl = 3'($urandom()); cfg_addr = 8'($urandom()); cfg_words = 8'($urandom());
    end
    @(posedge clk); #1;
    start = 0; abort = 0; req = 0;
    checks++;
    if (!obs_fin) begin
      errors++;
      $display("FAIL run_timeout: finished never seen, got 0 required 1");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    checks += 8;
    if (ch_instr !== INS_NOP) begin errors++; $display("FAIL rst_instr: got %0d req 3", ch_instr); end
    if (ch_din !== 8'h00) begin errors++; $display("FAIL rst_din: got %h req 00", ch_din); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b req 0", busy); end
    if (finished !== 1'b0) begin errors++; $display("FAIL rst_fin: got %b req 0", finished); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b req 0", err); end
    if (final_addr !== 8'h00) begin errors++; $display("FAIL rst_fa: got %h req 00", final_addr); end
    if (final_words !== 8'h00) begin errors++; $display("FAIL rst_fw: got %h req 00", final_words); end
    if (step_cnt !== 9'd0) begin errors++; $display("FAIL rst_cnt: got %0d req 0", step_cnt); end
  endtask

  task automatic test_basic();
    fill_req(100);
    ref_run(3'b000, 8'h10, 8'd3);
    do_run(3'b000, 8'h10, 8'd3, 0);
    checks += 5;
    if (obs_steps != 3) begin errors++; $display("FAIL basic_steps: got %0d req 3", obs_steps); end
    if (final_addr !== 8'h13) begin errors++; $display("FAIL basic_fa: got %h req 13", final_addr); end
    if (final_words !== e_fw) begin errors++; $display("FAIL basic_fw: got %h req %h", final_words, e_fw); end
    if (obs_cycles != 11) begin errors++; $display("FAIL basic_latency: got %0d req 11", obs_cycles); end
    if (err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b req 0", err); end
    last_fa = e_fa; last_fw = e_fw;
  endtask

  task automatic test_stall();
    fill_req(100);
    req_pat[6] = 0;
    ref_run(3'b100, 8'h05, 8'd2);
    do_run(3'b100, 8'h05, 8'd2, 0);
    checks += 4;
    if (obs_steps != 2) begin errors++; $display("FAIL stall_steps: got %0d req 2", obs_steps); end
    if (final_addr !== 8'h03) begin errors++; $display("FAIL stall_fa: got %h req 03", final_addr); end
    if (obs_cycles != e_cycles) begin errors++; $display("FAIL stall_latency: got %0d req %0d", obs_cycles, e_cycles); end
    if (step_cnt !== 9'd2) begin errors++; $display("FAIL stall_cnt: got %0d req 2", step_cnt); end
    last_fa = e_fa; last_fw = e_fw;
  endtask

  task automatic test_limit();
    fill_req(100);
    ref_run(3'b011, 8'h40, 8'h22);
    do_run(3'b011, 8'h40, 8'h22, 0);
    checks += 5;
    if (obs_steps != int'(MaxSteps)) begin errors++; $display("FAIL limit_steps: got %0d req %0d", obs_steps, MaxSteps); end
    if (step_cnt !== 9'(MaxSteps)) begin errors++; $display("FAIL limit_cnt: got %0d req %0d", step_cnt, MaxSteps); end
    if (err !== 1'b1) begin errors++; $display("FAIL limit_err: got %b req 1", err); end
    if (final_addr !== 8'h48) begin errors++; $display("FAIL limit_fa: got %h req 48", final_addr); end
    if (obs_cycles != e_cycles) begin errors++; $display("FAIL limit_latency: got %0d req %0d", obs_cycles, e_cycles); end
    last_fa = e_fa; last_fw = e_fw;
  endtask

  task automatic test_readback();
    fill_req(100);
    corrupt = 1;
    do_run(3'b001, 8'h20, 8'd4, 0);
    corrupt = 0;
    checks += 5;
    if (err !== 1'b1) begin errors++; $display("FAIL rdback_err: got %b req 1", err); end
    if (obs_bad != 0) begin errors++; $display("FAIL rdback_instrs: got %0d req 0", obs_bad); end
    if (step_cnt !== 9'd0) begin errors++; $display("FAIL rdback_cnt: got %0d req 0", step_cnt); end
    if (obs_cycles != 3) begin errors++; $display("FAIL rdback_latency: got %0d req 3", obs_cycles); end
    if (final_addr !== last_fa) begin errors++; $display("FAIL rdback_fa: got %h req %h", final_addr, last_fa); end
  endtask

  task automatic test_abort();
    fill_req(100);
    do_run(3'b000, 8'h30, 8'd10, 3);
    checks += 6;
    if (step_cnt !== 9'd3) begin errors++; $display("FAIL abort_cnt: got %0d req 3", step_cnt); end
    if (obs_steps != 3) begin errors++; $display("FAIL abort_steps: got %0d req 3", obs_steps); end
    if (err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b req 1", err); end
    if (obs_cycles != 9) begin errors++; $display("FAIL abort_latency: got %0d req 9", obs_cycles); end
    if (final_addr !== last_fa) begin errors++; $display("FAIL abort_fa: got %h req %h", final_addr, last_fa); end
    if (final_words !== last_fw) begin errors++; $display("FAIL abort_fw: got %h req %h", final_words, last_fw); end
    ref_run(3'b000, 8'h30, 8'd5);
    do_run(3'b000, 8'h30, 8'd5, 0);
    checks += 3;
    if (err !== 1'b0) begin errors++; $display("FAIL rerun_err: got %b req 0", err); end
    if (step_cnt !== 9'd5) begin errors++; $display("FAIL rerun_cnt: got %0d req 5", step_cnt); end
    if (final_addr !== 8'h35) begin errors++; $display("FAIL rerun_fa: got %h req 35", final_addr); end
    last_fa = e_fa; last_fw = e_fw;
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [2:0] c;
      logic [7:0] a, w;
      c = 3'($urandom());
      a = 8'($urandom());
      if (c[1:0] == MODE_ADDR_CMP)
        w = c[CTRL_DEC_BIT] ? a - 8'($urandom_range(1, 10)) : a + 8'($urandom_range(1, 10));
      else
        w = 8'($urandom_range(0, 11));
      fill_req(70);
      ref_run(c, a, w);
      do_run(c, a, w, 0);
      checks += 6;
      if (obs_steps != e_steps) begin errors++; $display("FAIL rnd%0d_steps: got %0d req %0d", n, obs_steps, e_steps); end
      if (step_cnt !== 9'(e_steps)) begin errors++; $display("FAIL rnd%0d_cnt: got %0d req %0d", n, step_cnt, e_steps); end
      if (err !== e_err) begin errors++; $display("FAIL rnd%0d_err: got %b req %b", n, err, e_err); end
      if (final_addr !== e_fa) begin errors++; $display("FAIL rnd%0d_fa: got %h req %h", n, final_addr, e_fa); end
      if (final_words !== e_fw) begin errors++; $display("FAIL rnd%0d_fw: got %h req %h", n, final_words, e_fw); end
      if (obs_cycles != e_cycles) begin errors++; $display("FAIL rnd%0d_latency: got %0d req %0d", n, obs_cycles, e_cycles); end
      last_fa = e_fa; last_fw = e_fw;
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    fill_req(100);
    @(posedge clk); #1;
    start = 1; cfg_ctrl = 3'b000; cfg_addr = 8'h77; cfg_words = 8'd4;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ch_instr == INS_LDWORD) begin
        reset = 1; hit = 1;
        break;
      end
      @(posedge clk); #1;
      start = 0;
    end
    @(posedge clk); #1;
    start = 0;
    checks += 7;
    if (!hit) begin errors++; $display("FAIL midrst_ldword: got 0 req 1"); end
    if (ch_instr !== INS_NOP) begin errors++; $display("FAIL midrst_instr: got %0d req 3", ch_instr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b req 0", busy); end
    if (ch_din !== 8'h00) begin errors++; $display("FAIL midrst_din: got %h req 00", ch_din); end
    if (err !== 1'b0 || finished !== 1'b0) begin errors++; $display("FAIL midrst_flags: got %b%b req 00", err, finished); end
    if (final_addr !== 8'h00 || final_words !== 8'h00) begin
      errors++; $display("FAIL midrst_final: got %h/%h req 00/00", final_addr, final_words);
    end
    if (step_cnt !== 9'd0) begin errors++; $display("FAIL midrst_cnt: got %0d req 0", step_cnt); end
    reset = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_limit();
    test_readback();
    test_abort();
    test_random();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
